// File: rtl/bus_xcvr_reg.sv
// bus_xcvr_reg: registered bidirectional bus transceiver with stored/live source select
// and a dead-time turnaround whenever the driving direction reverses.
module bus_xcvr_reg #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             dir,
    input  logic             oe_L,
    input  logic             sel,
    input  logic             cap_ab,
    input  logic             cap_ba,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic             a_oe,
    output logic [WIDTH-1:0] b_out,
    output logic             b_oe,
    output logic             busy
);
    typedef enum logic [1:0] {OFF, AB, BA, TURN} state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t           state_q, state_d, req;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_ab_q, reg_ba_q;
    logic             a_oe_q, b_oe_q, busy_q;

    always_comb begin
        req     = oe_L ? OFF : (dir ? AB : BA);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: state_d = req;
            AB, BA: begin
                if (req == OFF) begin
                    state_d = OFF;
                end else if (req != state_q) begin
                    state_d = TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            TURN: begin
                if (req == OFF || cnt_q == 4'd0) state_d = req;
                else cnt_d = cnt_q - 4'd1;
            end
            default: state_d = OFF;
        endcase
    end

    // Enables come straight from flops so the pad drivers never see decode glitches.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= OFF;
            cnt_q    <= 4'd0;
            reg_ab_q <= '0;
            reg_ba_q <= '0;
            a_oe_q   <= 1'b0;
            b_oe_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_oe_q  <= state_d == BA;
            b_oe_q  <= state_d == AB;
            busy_q  <= state_d == TURN;
            if (cap_ab) reg_ab_q <= a_in;
            if (cap_ba) reg_ba_q <= b_in;
        end
    end

    assign b_out = sel ? reg_ab_q : a_in;
    assign a_out = sel ? reg_ba_q : b_in;
    assign a_oe  = a_oe_q;
    assign b_oe  = b_oe_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_bus_xcvr_reg.sv
// tb_bus_xcvr_reg: vector table, directed corner sequences and a randomized run
// against a driver/dead-time model of the transceiver.
module tb_bus_xcvr_reg;
    localparam int TURN = 3;

    logic       clock, reset_L, dir, oe_L, sel, cap_ab, cap_ba;
    logic [7:0] a_in, b_in, a_out, b_out;
    logic       a_oe, b_oe, busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who drives (0 none, 1 A->B, 2 B->A) and how many dead cycles remain.
    int         m_drv, m_dead;
    logic [7:0] m_ab, m_ba;

    typedef struct {
        logic       oe_L, dir, sel, cab, cba;
        logic [7:0] a, b;
        logic       e_aoe, e_boe, e_busy;
        logic [7:0] e_aout, e_bout;
    } vec_t;

    vec_t vecs[12];

    bus_xcvr_reg #(.WIDTH(8), .TURN_CYCLES(TURN)) dut (
        .clock(clock), .reset_L(reset_L), .dir(dir), .oe_L(oe_L), .sel(sel),
        .cap_ab(cap_ab), .cap_ba(cap_ba), .a_in(a_in), .b_in(b_in),
        .a_out(a_out), .a_oe(a_oe), .b_out(b_out), .b_oe(b_oe), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_edge();
        int req;
        req = oe_L ? 0 : (dir ? 1 : 2);
        if (cap_ab) m_ab = a_in;
        if (cap_ba) m_ba = b_in;
        if (req == 0) begin
            m_drv  = 0;
            m_dead = 0;
        end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) m_drv = req;
        end else if (m_drv != 0 && req != m_drv) begin
            m_drv  = 0;
            m_dead = TURN;
        end else begin
            m_drv = req;
        end
    endtask

    initial begin
        //           oe dir sel cab cba  a      b      aoe  boe  busy aout   bout
        vecs[0]  = '{0, 1, 0, 0, 0, 8'hA5, 8'h00, 0, 1, 0, 8'h00, 8'hA5};
        vecs[1]  = '{0, 1, 0, 0, 0, 8'h3C, 8'h00, 0, 1, 0, 8'h00, 8'h3C};
        vecs[2]  = '{0, 0, 0, 0, 0, 8'h3C, 8'h77, 0, 0, 1, 8'h77, 8'h3C};
        vecs[3]  = '{0, 0, 0, 0, 0, 8'h3C, 8'h77, 0, 0, 1, 8'h77, 8'h3C};
        vecs[4]  = '{0, 0, 0, 0, 0, 8'h3C, 8'h77, 0, 0, 1, 8'h77, 8'h3C};
        vecs[5]  = '{0, 0, 0, 0, 0, 8'h3C, 8'h77, 1, 0, 0, 8'h77, 8'h3C};
        vecs[6]  = '{0, 0, 0, 1, 0, 8'h5A, 8'h77, 1, 0, 0, 8'h77, 8'h5A};
        vecs[7]  = '{0, 1, 1, 0, 0, 8'hFF, 8'h77, 0, 0, 1, 8'h00, 8'h5A};
        vecs[8]  = '{1, 1, 1, 0, 0, 8'hFF, 8'h77, 0, 0, 0, 8'h00, 8'h5A};
        vecs[9]  = '{0, 1, 1, 1, 1, 8'h11, 8'h22, 0, 1, 0, 8'h22, 8'h11};
        vecs[10] = '{0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h22, 8'h11};
        vecs[11] = '{1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h22, 8'h11};

        reset_L = 1'b0; oe_L = 1'b0; dir = 1'b1; sel = 1'b0;
        cap_ab = 1'b0; cap_ba = 1'b0; a_in = 8'h00; b_in = 8'h00;
        repeat (2) step();
        chk("reset_ctl", 32'({a_oe, b_oe, busy}), 32'(3'b000));
        reset_L = 1'b1;
        step();
        chk("reset_release_boe", 32'({a_oe, b_oe, busy}), 32'(3'b010));
        oe_L = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            oe_L = vecs[i].oe_L; dir = vecs[i].dir; sel = vecs[i].sel;
            cap_ab = vecs[i].cab; cap_ba = vecs[i].cba;
            a_in = vecs[i].a; b_in = vecs[i].b;
            step();
            chk($sformatf("vec%0d", i), 32'({a_oe, b_oe, busy, a_out, b_out}),
                32'({vecs[i].e_aoe, vecs[i].e_boe, vecs[i].e_busy, vecs[i].e_aout, vecs[i].e_bout}));
        end

        oe_L = 1'b0; dir = 1'b1; sel = 1'b0; a_in = 8'hA5;
        step();
        chk("live_a5", 32'({b_oe, b_out}), 32'({1'b1, 8'hA5}));
        a_in = 8'h3C;
        #1;
        chk("live_3c_noclk", 32'(b_out), 32'(8'h3C));

        // Reversal then an asynchronous reset in the middle of the dead time.
        dir = 1'b0;
        step();
        chk("turn_busy", 32'({a_oe, b_oe, busy}), 32'(3'b001));
        #2;
        sel = 1'b1; a_in = 8'hFF; b_in = 8'hEE;
        reset_L = 1'b0;
        #1;
        chk("async_rst_ctl", 32'({a_oe, b_oe, busy}), 32'(3'b000));
        chk("async_rst_regs", 32'({a_out, b_out}), 32'(16'h0000));
        reset_L = 1'b1;
        step();
        chk("post_rst_regs", 32'({a_out, b_out}), 32'(16'h0000));
        chk("post_rst_ba", 32'({a_oe, b_oe, busy}), 32'(3'b100));

        reset_L = 1'b0;
        m_drv = 0; m_dead = 0; m_ab = 8'h00; m_ba = 8'h00;
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            model_edge();
            #1;
            oe_L   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) dir = ~dir;
            sel    = 1'($urandom);
            cap_ab = ($urandom_range(0, 3) == 0);
            cap_ba = ($urandom_range(0, 3) == 0);
            a_in   = 8'($urandom);
            b_in   = 8'($urandom);
            #1;
            chk("rnd_ctl", 32'({a_oe, b_oe, busy}), 32'({m_drv == 2, m_drv == 1, m_dead > 0}));
            chk("rnd_a_out", 32'(a_out), 32'(sel ? m_ba : b_in));
            chk("rnd_b_out", 32'(b_out), 32'(sel ? m_ab : a_in));
            chk("rnd_excl", 32'(a_oe & b_oe), 32'(1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_xcvr_reg.md
Name: bus_xcvr_reg

Overview:
Parametrised registered bidirectional bus transceiver, the successor to the team's octal tristate transceiver. It adds per-direction storage registers with a live/stored source select, a direction state machine with a guaranteed dead-time turnaround, and registered output enables. It sits between two shared buses (e.g. CPU data bus and peripheral bus). Tristating is explicit: the block exposes separate in/out/oe per side, and the top level ties these to inout pads.

Parameters:
WIDTH, 8, data bits per side
TURN_CYCLES, 1, dead cycles with both sides disabled on a direction reversal; legal range 1..15

Ports:
clock  input  1  system clock, all state on rising edge
reset_L  input  1  asynchronous active-low reset
dir  input  1  requested direction: 1 = A drives B, 0 = B drives A
oe_L  input  1  active-low transceiver enable; 1 = both sides released
sel  input  1  data source: 0 = live opposite bus, 1 = stored register
cap_ab  input  1  capture a_in into reg_ab on this clock edge
cap_ba  input  1  capture b_in into reg_ba on this clock edge
a_in  input  WIDTH  sampled A bus
b_in  input  WIDTH  sampled B bus
a_out  output  WIDTH  data for A pads
a_oe  output  1  A pad driver enable
b_out  output  WIDTH  data for B pads
b_oe  output  1  B pad driver enable
busy  output  1  high while in TURN

Behaviour:
- Reset (reset_L low, asynchronous): state OFF; reg_ab and reg_ba = 0; turn counter = 0; a_oe = 0, b_oe = 0, busy = 0. a_out and b_out follow the data rules below. Takes effect mid-turnaround or mid-drive with no delay.
- Requested mode: OFF if oe_L = 1; otherwise AB if dir = 1, BA if dir = 0.
- States: OFF, AB, BA, TURN. State and the enables are registered, so enable changes appear one clock after the request.
- OFF -> AB or BA: next edge after the request. No dead time is needed because nothing is driving.
- AB or BA -> OFF: next edge. Drivers release with one-cycle latency.
- AB -> BA, or BA -> AB: go to TURN and load the counter with TURN_CYCLES-1. Both enables = 0 and busy = 1 while in TURN.
- TURN: if the request is OFF, go to OFF next edge. Otherwise decrement each cycle; at count 0, go to the requested mode (AB or BA, whichever is requested at that edge, which may be the original direction).
- Enables: b_oe = 1 exactly in state AB; a_oe = 1 exactly in state BA. a_oe and b_oe are never both 1 in the same cycle (invariant).
- Data: b_out = sel ? reg_ab : a_in; a_out = sel ? reg_ba : b_in. These paths are combinational. Values are don't-care to the pads when the matching enable is 0.
- Capture: cap_ab loads reg_ab <= a_in, and cap_ba loads reg_ba <= b_in, on the clock edge in any state, including TURN and OFF. Both captures may occur in the same cycle. A capture while sel = 1 shows the new value on the output from the following cycle.
- The oe_L and dir inputs are assumed synchronous to clock. Changes within a single cycle are acted on at the next edge only.

Test Plan:
- Reset/idle: reset_L = 0 with oe_L = 0, dir = 1 -> a_oe = b_oe = busy = 0; release reset -> b_oe = 1 one cycle later.
- Live pass-through: oe_L = 0, dir = 1, sel = 0, a_in = 8'hA5 -> b_oe = 1, b_out = 8'hA5 the same cycle; change a_in to 8'h3C -> b_out = 8'h3C with no clock.
- Turnaround: TURN_CYCLES = 3, in AB, flip dir to 0 -> exactly 3 cycles with a_oe = b_oe = 0 and busy = 1, then a_oe = 1; check the invariant on every cycle.
- Aborted turn: during TURN set oe_L = 1 -> OFF next edge, busy = 0; re-enable with dir = 1 -> b_oe = 1 one cycle later without a turnaround.
- Stored mode: cap_ab with a_in = 8'h5A, then a_in = 8'hFF, sel = 1, dir = 1 -> b_out = 8'h5A; simultaneous cap_ab/cap_ba with a_in = 8'h11, b_in = 8'h22 -> reg_ab = 8'h11, reg_ba = 8'h22.
- Async reset mid-turn: assert reset_L between edges while in TURN -> enables and busy drop immediately; stored registers read 0 after release.
